cu_seq: RTL and testbench
=========================

CU_SEQ -- requirements
Module: cu_seq

Interface
REQ-001 The block SHALL have parameter OPW, default 6, giving the opcode width in bits (minimum 5).
REQ-002 The block SHALL have parameter CSW, default 8, giving the control-word width {next, br/oth, aluOp, lse, ldm, lacc, abs, spo}, padded with zeros above bit 7.
REQ-003 The block SHALL have parameter FLW, default 4, giving the flag width {ovf, carry, neg, zero} from MSB to LSB.
REQ-004 The ports SHALL be as follows:
- clk in 1: single clock; all state changes on the rising edge.
- rst_n in 1: reset, asynchronous, active-low.
- instr_valid in 1: an opcode is offered.
- instr_ready out 1: the block accepts an opcode.
- opcode in OPW: the instruction opcode.
- flags in FLW: ALU status, sampled in EXEC.
- alu_done in 1: multi-cycle ALU operation complete.
- mem_ack in 1: memory access complete.
- ctrl out CSW: the registered control word.
- mem_req out 1: memory access request.
- mem_we out 1: write strobe, store only.
- br_taken out 1: branch-taken pulse.
- illegal out 1: sticky illegal-opcode indicator.

Function
REQ-005 The FSM SHALL use the states IDLE, DECODE, EXEC, MEM, WAIT_ALU and TRAP.
REQ-006 In IDLE, instr_ready SHALL be 1; it SHALL be 0 in every other state.
REQ-007 On instr_valid&instr_ready, the block SHALL capture opcode and move to DECODE.
REQ-008 DECODE SHALL last exactly 1 cycle and SHALL look up the control word from the package table.
REQ-009 From DECODE, the next state SHALL be:
- MEM for load (0) and store (1);
- TRAP for any opcode above 26;
- EXEC for all other opcodes.
REQ-010 In EXEC, ctrl SHALL hold the table word for exactly 1 cycle, after which the block SHALL return to IDLE.
REQ-011 Latency: an opcode accepted at cycle N SHALL drive ctrl at N+2, and instr_ready SHALL be 1 again at N+3.
REQ-012 Branch evaluation in EXEC SHALL follow these rules:
- brz, brn, brc and bro are taken iff flags[0], [1], [2] or [3] respectively is set.
- bra, jmp and ret are always taken.
- A taken branch SHALL set br_taken=1 and output the table word.
- A not-taken branch SHALL set ctrl=0 and br_taken=0.
REQ-013 In MEM, mem_req SHALL be 1 and ctrl SHALL hold the load/store word; mem_we SHALL be 1 only for store.
REQ-014 MEM SHALL stay until mem_ack=1, then return to IDLE; mem_ack arriving in the first MEM cycle SHALL give a 1-cycle MEM.
REQ-015 mem_ack outside MEM and alu_done outside WAIT_ALU SHALL be ignored.
REQ-016 In TRAP, the block SHALL drive ctrl to all ones and illegal=1; TRAP SHALL be left only by reset.
REQ-017 In IDLE and DECODE, ctrl, mem_req, mem_we and br_taken SHALL be 0.
REQ-018 All outputs SHALL be registered, with no combinational path from input to output.
REQ-019 mov (15) SHALL produce ctrl=0 in EXEC; it SHALL still count as a legal instruction.

Reset
REQ-020 Asserting rst_n=0 SHALL asynchronously force IDLE and set ctrl=0, mem_req=0, mem_we=0, br_taken=0 and illegal=0.
REQ-021 After reset, instr_ready SHALL be 1.
REQ-022 Reset during MEM SHALL drop mem_req immediately, and the aborted access SHALL NOT be retried.
REQ-023 The first accept SHALL occur no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-024 With macro CU_MULTICYCLE_ALU_EN defined, mul (16), div (17) and mod (18) SHALL go from EXEC to WAIT_ALU.
REQ-025 In WAIT_ALU, ctrl SHALL keep the ALU word until alu_done=1, then the block SHALL go to IDLE.
REQ-026 Without CU_MULTICYCLE_ALU_EN, mul, div and mod SHALL behave as single-cycle EXEC, and alu_done SHALL be unused.

Structure
REQ-027 Package cu_pkg SHALL hold:
- the opcode localparams (load=0 … dec=26);
- the state enum;
- the control-word constants: LOAD=8'b11011000, STORE=8'b10000000, BRC=8'b01000000 (conditional branch), BRU=8'b01000010 (unconditional branch), ALU=8'b10100100, MOV=0, TRAP=all ones.
REQ-028 A combinational sub-module cu_decode_rom SHALL map opcode to {ctrl word, class}, where class is one of MEM, BRCOND, BRUNC, ALU, ALUMC or ILLEGAL; the FSM SHALL remain in cu_seq.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Add: opcode 9 accepted at N -> ctrl=8'b10100100 at N+2 only, instr_ready=1 at N+3.
- brz: opcode 2 with flags=4'b0001 -> br_taken=1, ctrl=8'b01000000; the same opcode with flags=0 -> ctrl=0, br_taken=0.
- Load: opcode 0 with mem_ack after 3 cycles -> mem_req high 3 cycles, ctrl=8'b11011000, mem_we=0. Store: opcode 1 with mem_ack in the same cycle -> 1-cycle mem_req with mem_we=1.
- Illegal: opcode 6'd40 -> TRAP, ctrl=8'hFF, illegal=1 held through 10 further instr_valid pulses, instr_ready=0.
- Reset abort: rst_n pulsed low mid-MEM -> mem_req=0 within the same cycle, IDLE, illegal cleared.
- Multi-cycle ALU: with CU_MULTICYCLE_ALU_EN, opcode 16 with alu_done after 4 cycles -> ctrl held 5 cycles. Without the macro -> ctrl held 1 cycle.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared opcodes, FSM states, control-word constants and decode payload for cu_seq.
package cu_pkg;

   localparam int unsigned CW_W = 8;

   // Opcode map
   localparam int unsigned OP_LOAD  = 0;
   localparam int unsigned OP_STORE = 1;
   localparam int unsigned OP_BRZ   = 2;
   localparam int unsigned OP_BRN   = 3;
   localparam int unsigned OP_BRC   = 4;
   localparam int unsigned OP_BRO   = 5;
   localparam int unsigned OP_BRA   = 6;
   localparam int unsigned OP_JMP   = 7;
   localparam int unsigned OP_RET   = 8;
   localparam int unsigned OP_ADD   = 9;
   localparam int unsigned OP_SUB   = 10;
   localparam int unsigned OP_AND   = 11;
   localparam int unsigned OP_OR    = 12;
   localparam int unsigned OP_XOR   = 13;
   localparam int unsigned OP_NOT   = 14;
   localparam int unsigned OP_MOV   = 15;
   localparam int unsigned OP_MUL   = 16;
   localparam int unsigned OP_DIV   = 17;
   localparam int unsigned OP_MOD   = 18;
   localparam int unsigned OP_SHL   = 19;
   localparam int unsigned OP_SHR   = 20;
   localparam int unsigned OP_ROL   = 21;
   localparam int unsigned OP_ROR   = 22;
   localparam int unsigned OP_CMP   = 23;
   localparam int unsigned OP_NEG   = 24;
   localparam int unsigned OP_INC   = 25;
   localparam int unsigned OP_DEC   = 26;

   // Control words {next, br/oth, aluOp, lse, ldm, lacc, abs, spo}
   localparam logic [CW_W-1:0] CW_LOAD  = 8'b1101_1000;
   localparam logic [CW_W-1:0] CW_STORE = 8'b1000_0000;
   localparam logic [CW_W-1:0] CW_BRC   = 8'b0100_0000;
   localparam logic [CW_W-1:0] CW_BRU   = 8'b0100_0010;
   localparam logic [CW_W-1:0] CW_ALU   = 8'b1010_0100;
   localparam logic [CW_W-1:0] CW_MOV   = 8'b0000_0000;
   localparam logic [CW_W-1:0] CW_TRAP  = 8'b1111_1111;

   typedef enum logic [2:0] {
      IDLE, DECODE, EXEC, MEM, WAIT_ALU, TRAP
   } state_e;

   typedef enum logic [2:0] {
      CL_MEM, CL_BRCOND, CL_BRUNC, CL_ALU, CL_ALUMC, CL_ILLEGAL
   } op_class_e;

   // Decoder payload: table word, class, branch flag select, store strobe
   typedef struct packed {
      logic [CW_W-1:0] cw;
      op_class_e       cls;
      logic [1:0]      flag_sel;
      logic            we;
   } dec_t;

endpackage

// File: rtl/cu_decode_rom.sv
// Combinational opcode -> {control word, class} lookup.
module cu_decode_rom
   import cu_pkg::*;
#(
   parameter int unsigned OPW = 6
) (
   input  logic [OPW-1:0] i_opcode,
   output dec_t           o_dec
);

   logic [31:0] w_op;

   // Table lookup; anything past OP_DEC falls through as illegal
   always_comb begin
      w_op           = 32'(i_opcode);
      o_dec.cw       = '0;
      o_dec.cls      = CL_ILLEGAL;
      o_dec.flag_sel = 2'd0;
      o_dec.we       = 1'b0;
      case (w_op)
         OP_LOAD: begin
            o_dec.cw  = CW_LOAD;
            o_dec.cls = CL_MEM;
         end
         OP_STORE: begin
            o_dec.cw  = CW_STORE;
            o_dec.cls = CL_MEM;
            o_dec.we  = 1'b1;
         end
         OP_BRZ, OP_BRN, OP_BRC, OP_BRO: begin
            o_dec.cw       = CW_BRC;
            o_dec.cls      = CL_BRCOND;
            o_dec.flag_sel = 2'(w_op - OP_BRZ);
         end
         OP_BRA, OP_JMP, OP_RET: begin
            o_dec.cw  = CW_BRU;
            o_dec.cls = CL_BRUNC;
         end
         OP_MOV: begin
            o_dec.cw  = CW_MOV;
            o_dec.cls = CL_ALU;
         end
         OP_MUL, OP_DIV, OP_MOD: begin
            o_dec.cw  = CW_ALU;
            o_dec.cls = CL_ALUMC;
         end
         default: begin
            if (w_op <= OP_DEC) begin
               o_dec.cw  = CW_ALU;
               o_dec.cls = CL_ALU;
            end
         end
      endcase
   end

endmodule

// File: rtl/cu_seq.sv
// Control-unit sequencer: accepts opcodes, decodes, and drives registered
// control words through EXEC / MEM / WAIT_ALU / TRAP.
// Optional macro CU_MULTICYCLE_ALU_EN: mul/div/mod wait in WAIT_ALU for alu_done.
module cu_seq
   import cu_pkg::*;
#(
   parameter int unsigned OPW = 6,
   parameter int unsigned CSW = 8,
   parameter int unsigned FLW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           instr_valid,
   output logic           instr_ready,
   input  logic [OPW-1:0] opcode,
   input  logic [FLW-1:0] flags,
   input  logic           alu_done,
   input  logic           mem_ack,
   output logic [CSW-1:0] ctrl,
   output logic           mem_req,
   output logic           mem_we,
   output logic           br_taken,
   output logic           illegal
);

   state_e         r_state, w_state_nxt;
   logic [OPW-1:0] r_opcode;
   logic [CSW-1:0] r_ctrl, w_ctrl_nxt;
   logic           r_ready, w_ready_nxt;
   logic           r_mem_req, w_mem_req_nxt;
   logic           r_mem_we, w_mem_we_nxt;
   logic           r_br_taken, w_br_taken_nxt;
   logic           r_illegal, w_illegal_nxt;
   dec_t           w_dec;

`ifndef CU_MULTICYCLE_ALU_EN
   logic w_unused_alu_done;
   assign w_unused_alu_done = alu_done;
`endif

   cu_decode_rom #(.OPW(OPW)) u_rom (
      .i_opcode (r_opcode),
      .o_dec    (w_dec)
   );

   // State and registered outputs; outputs are computed for the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_opcode   <= '0;
         r_ctrl     <= '0;
         r_ready    <= 1'b1;
         r_mem_req  <= 1'b0;
         r_mem_we   <= 1'b0;
         r_br_taken <= 1'b0;
         r_illegal  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         if (instr_valid && r_ready) r_opcode <= opcode;
         r_ctrl     <= w_ctrl_nxt;
         r_ready    <= w_ready_nxt;
         r_mem_req  <= w_mem_req_nxt;
         r_mem_we   <= w_mem_we_nxt;
         r_br_taken <= w_br_taken_nxt;
         r_illegal  <= w_illegal_nxt;
      end
   end

   // Next-state and next-output decode
   always_comb begin
      w_state_nxt    = r_state;
      w_ctrl_nxt     = '0;
      w_ready_nxt    = 1'b0;
      w_mem_req_nxt  = 1'b0;
      w_mem_we_nxt   = 1'b0;
      w_br_taken_nxt = 1'b0;
      w_illegal_nxt  = r_illegal;
      case (r_state)
         IDLE: begin
            if (instr_valid) w_state_nxt = DECODE;
            else             w_ready_nxt = 1'b1;
         end
         DECODE: begin
            case (w_dec.cls)
               CL_MEM: begin
                  w_state_nxt   = MEM;
                  w_ctrl_nxt    = CSW'(w_dec.cw);
                  w_mem_req_nxt = 1'b1;
                  w_mem_we_nxt  = w_dec.we;
               end
               CL_BRCOND: begin
                  w_state_nxt = EXEC;
                  if (flags[w_dec.flag_sel]) begin
                     w_ctrl_nxt     = CSW'(w_dec.cw);
                     w_br_taken_nxt = 1'b1;
                  end
               end
               CL_BRUNC: begin
                  w_state_nxt    = EXEC;
                  w_ctrl_nxt     = CSW'(w_dec.cw);
                  w_br_taken_nxt = 1'b1;
               end
               CL_ALU, CL_ALUMC: begin
                  w_state_nxt = EXEC;
                  w_ctrl_nxt  = CSW'(w_dec.cw);
               end
               default: begin
                  w_state_nxt   = TRAP;
                  w_ctrl_nxt    = '1;
                  w_illegal_nxt = 1'b1;
               end
            endcase
         end
         EXEC: begin
`ifdef CU_MULTICYCLE_ALU_EN
            if (w_dec.cls == CL_ALUMC) begin
               w_state_nxt = WAIT_ALU;
               w_ctrl_nxt  = r_ctrl;
            end else begin
               w_state_nxt = IDLE;
               w_ready_nxt = 1'b1;
            end
`else
            w_state_nxt = IDLE;
            w_ready_nxt = 1'b1;
`endif
         end
         MEM: begin
            if (mem_ack) begin
               w_state_nxt = IDLE;
               w_ready_nxt = 1'b1;
            end else begin
               w_ctrl_nxt    = r_ctrl;
               w_mem_req_nxt = 1'b1;
               w_mem_we_nxt  = r_mem_we;
            end
         end
         WAIT_ALU: begin
`ifdef CU_MULTICYCLE_ALU_EN
            if (alu_done) begin
               w_state_nxt = IDLE;
               w_ready_nxt = 1'b1;
            end else begin
               w_ctrl_nxt = r_ctrl;
            end
`else
            w_state_nxt = IDLE;
            w_ready_nxt = 1'b1;
`endif
         end
         TRAP: begin
            w_ctrl_nxt    = '1;
            w_illegal_nxt = 1'b1;
         end
         default: begin
            w_state_nxt = IDLE;
            w_ready_nxt = 1'b1;
         end
      endcase
   end

   assign instr_ready = r_ready;
   assign ctrl        = r_ctrl;
   assign mem_req     = r_mem_req;
   assign mem_we      = r_mem_we;
   assign br_taken    = r_br_taken;
   assign illegal     = r_illegal;

endmodule

// File: tb/tb_cu_seq.sv
// Directed bench for cu_seq; observes {ctrl, instr_ready, mem_req, mem_we, br_taken, illegal}.
module tb_cu_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       instr_valid = 1'b0;
   logic       instr_ready;
   logic [5:0] opcode = '0;
   logic [3:0] flags = '0;
   logic       alu_done = 1'b0;
   logic       mem_ack = 1'b0;
   logic [7:0] ctrl;
   logic       mem_req, mem_we, br_taken, illegal;

   int total = 0;
   int bad   = 0;

   wire [12:0] obs = {ctrl, instr_ready, mem_req, mem_we, br_taken, illegal};

   localparam logic [12:0] QUIET_IDLE = {8'h00, 5'b10000};
   localparam logic [12:0] QUIET_BUSY = {8'h00, 5'b00000};

   cu_seq dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .opcode      (opcode),
      .flags       (flags),
      .alu_done    (alu_done),
      .mem_ack     (mem_ack),
      .ctrl        (ctrl),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .br_taken    (br_taken),
      .illegal     (illegal)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Offer one opcode for a single cycle; returns in the DECODE cycle
   task automatic issue(input logic [5:0] op);
      opcode      = op;
      instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n       = 1'b0;
      instr_valid = 1'b1;
      opcode      = 6'd9;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++;
      if (obs !== QUIET_IDLE) begin
         bad++; $display("FAIL reset_hold: got %h want %h", obs, QUIET_IDLE);
      end
      step();
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (obs !== QUIET_IDLE) begin
         bad++; $display("FAIL reset_release: got %h want %h", obs, QUIET_IDLE);
      end
      step();
      instr_valid = 1'b0;
      @(negedge clk);
      total++;
      if (obs !== QUIET_BUSY) begin
         bad++; $display("FAIL reset_first_accept: got %h want %h", obs, QUIET_BUSY);
      end
      step();
      step();
   endtask

   task automatic test_add;
      issue(6'd9);
      @(negedge clk);
      total++;
      if (obs !== QUIET_BUSY) begin
         bad++; $display("FAIL add_decode: got %h want %h", obs, QUIET_BUSY);
      end
      step();
      @(negedge clk);
      total++;
      if (obs !== {8'hA4, 5'b00000}) begin
         bad++; $display("FAIL add_exec: got %h want %h", obs, {8'hA4, 5'b00000});
      end
      step();
      @(negedge clk);
      total++;
      if (obs !== QUIET_IDLE) begin
         bad++; $display("FAIL add_ready: got %h want %h", obs, QUIET_IDLE);
      end
   endtask

   task automatic test_branch;
      logic [5:0] ops   [9] = '{6'd2, 6'd2, 6'd3, 6'd5, 6'd4, 6'd6, 6'd8, 6'd15, 6'd26};
      logic [3:0] flv   [9] = '{4'b0001, 4'b0000, 4'b0010, 4'b0111, 4'b0100,
                                4'b0000, 4'b0000, 4'b1111, 4'b0000};
      logic [7:0] wctl  [9] = '{8'h40, 8'h00, 8'h40, 8'h00, 8'h40, 8'h42, 8'h42, 8'h00, 8'hA4};
      logic       wbr   [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [12:0] want;
      for (int i = 0; i < 9; i++) begin
         flags = flv[i];
         issue(ops[i]);
         step();
         @(negedge clk);
         want = {wctl[i], 1'b0, 1'b0, 1'b0, wbr[i], 1'b0};
         total++;
         if (obs !== want) begin
            bad++; $display("FAIL branch_exec op=%0d flags=%b: got %h want %h", ops[i], flv[i], obs, want);
         end
         step();
      end
      flags = '0;
      @(negedge clk);
      total++;
      if (obs !== QUIET_IDLE) begin
         bad++; $display("FAIL branch_pulse_end: got %h want %h", obs, QUIET_IDLE);
      end
   endtask

   task automatic test_ignored;
      mem_ack  = 1'b1;
      alu_done = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         @(negedge clk);
         total++;
         if (obs !== QUIET_IDLE) begin
            bad++; $display("FAIL ignored_idle: got %h want %h", obs, QUIET_IDLE);
         end
      end
      mem_ack  = 1'b0;
      alu_done = 1'b0;
      step();
   endtask

   task automatic test_load;
      int n;
      n = 0;
      issue(6'd0);
      step();
      @(negedge clk);
      total++;
      if (obs !== {8'hD8, 5'b01000}) begin
         bad++; $display("FAIL load_mem: got %h want %h", obs, {8'hD8, 5'b01000});
      end
      for (int i = 1; i <= 10; i++) begin
         if (i > 1) @(negedge clk);
         if (mem_req !== 1'b1) break;
         n++;
         mem_ack = (i == 3);
         step();
      end
      mem_ack = 1'b0;
      total++;
      if (n !== 3) begin
         bad++; $display("FAIL load_req_cycles: got %0d want %0d", n, 3);
      end
      total++;
      if (obs !== QUIET_IDLE) begin
         bad++; $display("FAIL load_done: got %h want %h", obs, QUIET_IDLE);
      end
   endtask

   task automatic test_store;
      issue(6'd1);
      step();
      mem_ack = 1'b1;
      @(negedge clk);
      total++;
      if (obs !== {8'h80, 5'b01100}) begin
         bad++; $display("FAIL store_mem: got %h want %h", obs, {8'h80, 5'b01100});
      end
      step();
      mem_ack = 1'b0;
      @(negedge clk);
      total++;
      if (obs !== QUIET_IDLE) begin
         bad++; $display("FAIL store_done: got %h want %h", obs, QUIET_IDLE);
      end
   endtask

   // Opcode held valid: accept every third cycle, ctrl two cycles after each accept
   task automatic test_back_to_back;
      logic [12:0] want;
      step();
      instr_valid = 1'b1;
      opcode      = 6'd10;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         if (c % 3 == 0)      want = QUIET_IDLE;
         else if (c % 3 == 1) want = QUIET_BUSY;
         else                 want = {8'hA4, 5'b00000};
         total++;
         if (obs !== want) begin
            bad++; $display("FAIL b2b cycle=%0d: got %h want %h", c, obs, want);
         end
         step();
      end
      instr_valid = 1'b0;
   endtask

   task automatic test_alu_mc;
      int n;
      int want_n;
`ifdef CU_MULTICYCLE_ALU_EN
      want_n = 5;
`else
      want_n = 1;
`endif
      n = 0;
      issue(6'd16);
      step();
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (ctrl !== 8'hA4) break;
         n++;
         alu_done = (i == 5);
         step();
      end
      alu_done = 1'b0;
      total++;
      if (n !== want_n) begin
         bad++; $display("FAIL alu_mc_hold: got %0d want %0d", n, want_n);
      end
      total++;
      if (obs !== QUIET_IDLE) begin
         bad++; $display("FAIL alu_mc_done: got %h want %h", obs, QUIET_IDLE);
      end
      step();
   endtask

   task automatic test_reset_abort;
      issue(6'd0);
      step();
      @(negedge clk);
      total++;
      if (obs !== {8'hD8, 5'b01000}) begin
         bad++; $display("FAIL abort_in_mem: got %h want %h", obs, {8'hD8, 5'b01000});
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (obs !== QUIET_IDLE) begin
         bad++; $display("FAIL abort_async: got %h want %h", obs, QUIET_IDLE);
      end
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (obs !== QUIET_IDLE) begin
            bad++; $display("FAIL abort_no_retry cycle=%0d: got %h want %h", i, obs, QUIET_IDLE);
         end
         step();
      end
   endtask

   task automatic test_illegal;
      issue(6'd40);
      @(negedge clk);
      total++;
      if (obs !== QUIET_BUSY) begin
         bad++; $display("FAIL illegal_decode: got %h want %h", obs, QUIET_BUSY);
      end
      step();
      @(negedge clk);
      total++;
      if (obs !== {8'hFF, 5'b00001}) begin
         bad++; $display("FAIL trap_enter: got %h want %h", obs, {8'hFF, 5'b00001});
      end
      for (int i = 0; i < 10; i++) begin
         instr_valid = 1'b1;
         opcode      = 6'd9;
         step();
         instr_valid = 1'b0;
         @(negedge clk);
         total++;
         if (obs !== {8'hFF, 5'b00001}) begin
            bad++; $display("FAIL trap_sticky pulse=%0d: got %h want %h", i, obs, {8'hFF, 5'b00001});
         end
         step();
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (obs !== QUIET_IDLE) begin
         bad++; $display("FAIL trap_reset: got %h want %h", obs, QUIET_IDLE);
      end
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_add();
      test_branch();
      test_ignored();
      test_load();
      test_store();
      test_back_to_back();
      test_alu_mc();
      test_reset_abort();
      test_illegal();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
